line_mem_responder: RTL and testbench

Line-granular main-memory responder serving the cache's miss path: accepts one line read (swap-in) or line write (swap-out) at a time, models a fixed access latency followed by a word-serial transfer to a single-port word array, then pulses a one-cycle grant. Port-compatible with the cache's memory-side interface (`addr`/`rd_req`/`wr_req`/`rd_line`/`wr_line`/`gnt`), so it drops in as the memory behind any cache instance.

---
 rtl/line_mem_responder.sv | 103 ++++++++++
 tb/tb_line_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Line-granular main-memory model for a cache miss path: fixed latency, then a
// word-serial transfer to a single-port word array, then a one-cycle grant.
module line_mem_responder #(
   parameter int unsigned LINE_ADDR_LEN = 3,
   parameter int unsigned ADDR_LEN      = 10,
   parameter int unsigned LATENCY       = 8,
   localparam int unsigned LINE_SIZE    = 1 << LINE_ADDR_LEN
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        gnt,
   input  logic [ADDR_LEN-1:0]         addr,
   input  logic                        rd_req,
   output logic [LINE_SIZE-1:0][31:0]  rd_line,
   input  logic                        wr_req,
   input  logic [LINE_SIZE-1:0][31:0]  wr_line,
   output logic                        busy
);

   localparam int unsigned WORD_ADDR_LEN = ADDR_LEN + LINE_ADDR_LEN;
   localparam int unsigned WORDS         = 1 << WORD_ADDR_LEN;
   localparam int unsigned LAT_W         = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

   state_t                       state, state_nxt;
   logic [LAT_W-1:0]             lat_cnt;
   logic [LINE_ADDR_LEN-1:0]     word_cnt;
   logic [ADDR_LEN-1:0]          line_addr;
   logic                         op_wr;
   logic [LINE_SIZE-1:0][31:0]   snap;
   logic [31:0]                  mem [WORDS];
   // Words never written read back as their own index, giving the power-up image.
   logic [WORDS-1:0]             written = '0;
   logic [WORD_ADDR_LEN-1:0]     word_idx;
   logic [31:0]                  rd_word;
   logic                         accept;
   logic                         lat_done;
   logic                         last_word;

   assign word_idx  = {line_addr, word_cnt};
   assign rd_word   = written[word_idx] ? mem[word_idx] : 32'(word_idx);
   assign lat_done  = (lat_cnt == LAT_W'(LATENCY - 1));
   assign last_word = (word_cnt == {LINE_ADDR_LEN{1'b1}});
   assign gnt       = (state == RESP);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: if (wr_req || rd_req) begin
            accept    = 1'b1;
            state_nxt = (LATENCY == 0) ? XFER : WAIT;
         end
         WAIT: if (lat_done) state_nxt = XFER;
         XFER: if (last_word) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt   <= '0;
         word_cnt  <= '0;
         line_addr <= '0;
         op_wr     <= 1'b0;
         snap      <= '0;
         rd_line   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               line_addr <= addr;
               op_wr     <= wr_req;
               if (wr_req) snap <= wr_line;
               word_cnt  <= '0;
               lat_cnt   <= '0;
            end
            WAIT: lat_cnt <= lat_cnt + LAT_W'(1);
            XFER: begin
               word_cnt <= word_cnt + LINE_ADDR_LEN'(1);
               if (!op_wr) rd_line[word_cnt] <= rd_word;
            end
            default: ;
         endcase
      end
   end

   // Storage is not reset; an aborted write keeps the words already stored.
   always_ff @(posedge clk) begin
      if (state == XFER && op_wr) begin
         mem[word_idx]     <= snap[word_cnt];
         written[word_idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: default build plus a LATENCY=0 build.
module tb_line_mem_responder;

   typedef logic [7:0][31:0] line_t;
   typedef struct {line_t line; int acc;} exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        gnt, busy, rd_req, wr_req;
   logic [9:0]  addr;
   line_t       rd_line, wr_line;

   logic        gnt0, busy0, rd_req0, wr_req0;
   logic [9:0]  addr0;
   line_t       rd_line0, wr_line0;

   exp_t q[$];
   exp_t q0[$];
   exp_t me, me0;
   int   cyc = 0;
   int   checks = 0, failures = 0;
   int   gnt_n = 0, gnt0_n = 0, push_n = 0, push0_n = 0;
   int   g_prev = 0, g_last = 0;
   line_t l9;

   line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(10), .LATENCY(8)) dut (
      .clk(clk), .rst(rst), .gnt(gnt), .addr(addr), .rd_req(rd_req),
      .rd_line(rd_line), .wr_req(wr_req), .wr_line(wr_line), .busy(busy));

   line_mem_responder #(.LINE_ADDR_LEN(3), .ADDR_LEN(10), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .gnt(gnt0), .addr(addr0), .rd_req(rd_req0),
      .rd_line(rd_line0), .wr_req(wr_req0), .wr_line(wr_line0), .busy(busy0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic line_t seq(input logic [31:0] base);
      line_t l;
      for (int k = 0; k < 8; k++) l[k] = base + 32'(k);
      return l;
   endfunction

   task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", n, act, exp);
      end
   endtask

   // Monitor, default build
   always @(negedge clk) begin
      if (gnt) begin
         gnt_n++;
         g_prev = g_last;
         g_last = cyc;
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_gnt at cycle %0d got=1 want=0", cyc);
         end else begin
            me = q.pop_front();
            chk("latency", 256'(cyc - me.acc), 256'(16));
            chk("rd_line_at_gnt", rd_line, me.line);
            @(negedge clk);
            chk("gnt_single", 256'(gnt), 256'(0));
            chk("busy_after_gnt", 256'(busy), 256'(0));
            chk("rd_line_after_gnt", rd_line, me.line);
         end
      end
   end

   // Monitor, LATENCY=0 build
   always @(negedge clk) begin
      if (gnt0) begin
         gnt0_n++;
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_gnt0 at cycle %0d got=1 want=0", cyc);
         end else begin
            me0 = q0.pop_front();
            chk("latency0", 256'(cyc - me0.acc), 256'(8));
            chk("rd_line0_at_gnt", rd_line0, me0.line);
            @(negedge clk);
            chk("gnt0_single", 256'(gnt0), 256'(0));
            chk("busy0_after_gnt", 256'(busy0), 256'(0));
         end
      end
   end

   task automatic start(input bit d0, input bit wr, input bit rd, input int a,
                        input line_t data, input line_t exp, input bit push);
      if (d0) begin
         addr0 = 10'(a); wr_line0 = data; wr_req0 = wr; rd_req0 = rd;
         if (push) begin q0.push_back('{exp, cyc + 1}); push0_n++; end
      end else begin
         addr = 10'(a); wr_line = data; wr_req = wr; rd_req = rd;
         if (push) begin q.push_back('{exp, cyc + 1}); push_n++; end
      end
   endtask

   task automatic wait_gnt(input bit d0);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = d0 ? gnt0 : gnt;
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL gnt_timeout dut_sel=%0d got=no_gnt want=gnt", d0);
      end
   endtask

   task automatic finish(input bit d0);
      wait_gnt(d0);
      if (d0) begin wr_req0 = 1'b0; rd_req0 = 1'b0; end
      else begin wr_req = 1'b0; rd_req = 1'b0; end
      @(negedge clk);
   endtask

   task automatic xact(input bit d0, input bit wr, input bit rd, input int a,
                       input line_t data, input line_t exp);
      start(d0, wr, rd, a, data, exp, 1'b1);
      finish(d0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_req = 0; wr_req = 0; addr = '0; wr_line = '0;
      rd_req0 = 0; wr_req0 = 0; addr0 = '0; wr_line0 = '0;
      repeat (3) @(negedge clk);
      chk("reset_gnt", 256'(gnt), 256'(0));
      chk("reset_busy", 256'(busy), 256'(0));
      chk("reset_rd_line", rd_line, '0);
      chk("reset_rd_line0", rd_line0, '0);
      rst = 1'b0;
      @(negedge clk);

      xact(0, 0, 1, 5, '0, seq(32'd40));
      xact(0, 1, 0, 5, seq(32'hA000_0000), seq(32'd40));
      xact(0, 0, 1, 5, '0, seq(32'hA000_0000));
      xact(0, 0, 1, 6, '0, seq(32'd48));

      // swap-out then swap-in: read raised in the RESP cycle, accepted two edges later
      start(0, 1, 0, 7, seq(32'hB000_0000), seq(32'd48), 1'b1);
      wait_gnt(0);
      wr_req = 1'b0; rd_req = 1'b1; addr = 10'd7;
      q.push_back('{seq(32'hB000_0000), cyc + 2});
      push_n++;
      finish(0);
      chk("b2b_spacing", 256'(g_last - g_prev), 256'(18));

      start(0, 1, 0, 12, seq(32'hC000_0000), seq(32'hB000_0000), 1'b1);
      @(negedge clk);
      addr = 10'd13; wr_line = seq(32'h5555_0000);
      finish(0);
      xact(0, 0, 1, 12, '0, seq(32'hC000_0000));
      xact(0, 0, 1, 13, '0, seq(32'd104));

      // abort a write of line 9 after three words
      start(0, 1, 0, 9, seq(32'hD000_0000), '0, 1'b0);
      repeat (12) @(negedge clk);
      rst = 1'b1; wr_req = 1'b0;
      #1;
      chk("abort_gnt", 256'(gnt), 256'(0));
      chk("abort_busy", 256'(busy), 256'(0));
      chk("abort_rd_line", rd_line, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_no_gnt", 256'(gnt_n), 256'(push_n));
      l9 = seq(32'd72);
      for (int k = 0; k < 3; k++) l9[k] = 32'hD000_0000 + 32'(k);
      xact(0, 0, 1, 9, '0, l9);

      xact(1, 0, 1, 2, '0, seq(32'd16));
      xact(1, 1, 1, 3, seq(32'hE000_0000), seq(32'd16));
      xact(1, 0, 1, 3, '0, seq(32'hE000_0000));

      repeat (3) @(negedge clk);
      chk("gnt_count", 256'(gnt_n), 256'(push_n));
      chk("gnt0_count", 256'(gnt0_n), 256'(push0_n));
      chk("queue_empty", 256'(q.size() + q0.size()), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
